// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store path
// (port 0) and the debug/loader port (port 1) with round-robin arbitration.
// The selected request is turned into a word address plus byte enables.
// Store data is replicated across lanes. Load data is extracted from the
// addressed lane, then sign- or zero-extended into a registered response.
//
// Optional feature: define DMEM_ARB_LOCK_EN to honour req_lock_i. When it
// is defined, an accepted request with lock set keeps the grant on its port
// until that port issues an accepted request with lock clear.
//
// Handshake: a request is accepted in a cycle when req_valid_i[p] and
// req_ready_o[p] are both high. At most one port is ready per cycle. The
// response for an accepted request appears on resp_*_o[p] for exactly the
// following cycle. There is no response backpressure.
//
// Ports (per-port signals are indexed [p], p = 0,1):
//   clk, rst                    clock, synchronous active-high reset
//   req_valid_i / req_ready_o   request handshake
//   req_we_i                    1 = store, 0 = load
//   req_addr_i                  byte address
//   req_wdata_i                 right-aligned store data
//   req_size_i                  0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned_i              zero-extend loads when set
//   req_lock_i                  hold grant after this access (lock build only)
//   resp_valid_o                one-cycle response pulse
//   resp_rdata_o                extended load data, 0 for stores/errors
//   resp_err_o                  misaligned or illegal-size request
//   mem_valid_o, mem_we_o       memory strobe and write enable
//   mem_addr_o                  word-aligned byte address
//   mem_wdata_o                 lane-replicated store data
//   mem_byte_enable_o           byte-lane enables
//   mem_rdata_i                 combinational read data for mem_addr_o
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0]           req_we_i,
    input  logic [1:0][XLEN-1:0] req_addr_i,
    input  logic [1:0][XLEN-1:0] req_wdata_i,
    input  logic [1:0][1:0]      req_size_i,
    input  logic [1:0]           req_unsigned_i,
    input  logic [1:0]           req_lock_i,
    output logic [1:0]           resp_valid_o,
    output logic [1:0][XLEN-1:0] resp_rdata_o,
    output logic [1:0]           resp_err_o,
    output logic                 mem_valid_o,
    output logic                 mem_we_o,
    output logic [XLEN-1:0]      mem_addr_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    output logic [3:0]           mem_byte_enable_o,
    input  logic [XLEN-1:0]      mem_rdata_i
);

    // Priority pointer: port favoured when both ports request.
    logic prio_q, prio_d;

    logic [1:0]           resp_valid_q;
    logic [1:0][XLEN-1:0] resp_rdata_q;
    logic [1:0]           resp_err_q;

    logic [1:0]      elig;
    logic [1:0]      grant;
    logic            accept;
    logic            sel;
    logic            s_we;
    logic [XLEN-1:0] s_addr;
    logic [XLEN-1:0] s_wdata;
    logic [1:0]      s_size;
    logic            s_uns;
    logic            legal;
    logic            go;
    logic [3:0]      be_raw;
    logic [XLEN-1:0] wdata_rep;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] resp_data;

`ifdef DMEM_ARB_LOCK_EN
    logic locked_q, locked_d;
    logic owner_q, owner_d;
`else
    // Lock inputs have no effect in this build.
    logic unused_lock;
    assign unused_lock = ^req_lock_i;
`endif

    // Arbitration and request selection.
    always_comb begin
        elig = req_valid_i;
`ifdef DMEM_ARB_LOCK_EN
        // While locked only the owner may be granted, even if it is idle.
        if (locked_q) begin
            elig = owner_q ? (req_valid_i & 2'b10) : (req_valid_i & 2'b01);
        end
`endif
        // Nothing is accepted while reset is asserted.
        if (rst) begin
            elig = 2'b00;
        end
        case (elig)
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = elig;
        endcase
        accept  = |grant;
        sel     = grant[1];
        s_we    = req_we_i[sel];
        s_addr  = req_addr_i[sel];
        s_wdata = req_wdata_i[sel];
        s_size  = req_size_i[sel];
        s_uns   = req_unsigned_i[sel];
    end

    assign req_ready_o = grant;

    // Alignment check, byte enables and store-lane replication.
    always_comb begin
        case (s_size)
            2'd0:    legal = 1'b1;
            2'd1:    legal = ~s_addr[0];
            2'd2:    legal = (s_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
        case (s_size)
            2'd0:    be_raw = 4'b0001 << s_addr[1:0];
            2'd1:    be_raw = 4'b0011 << s_addr[1:0];
            default: be_raw = 4'b1111;
        endcase
        case (s_size)
            2'd0:    wdata_rep = {4{s_wdata[7:0]}};
            2'd1:    wdata_rep = {2{s_wdata[15:0]}};
            default: wdata_rep = s_wdata;
        endcase
        go = accept & legal;
    end

    assign mem_valid_o       = go;
    assign mem_we_o          = go & s_we;
    assign mem_byte_enable_o = go ? be_raw : 4'b0000;
    assign mem_addr_o        = {s_addr[XLEN-1:2], 2'b00};
    assign mem_wdata_o       = wdata_rep;

    // Load lane extraction and extension.
    always_comb begin
        case (s_addr[1:0])
            2'd0:    lane_b = mem_rdata_i[7:0];
            2'd1:    lane_b = mem_rdata_i[15:8];
            2'd2:    lane_b = mem_rdata_i[23:16];
            default: lane_b = mem_rdata_i[31:24];
        endcase
        lane_h = s_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (s_size)
            2'd0:    load_ext = s_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_ext = s_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = mem_rdata_i;
        endcase
        // Stores and rejected requests answer with zero data.
        resp_data = (go && !s_we) ? load_ext : '0;
    end

    // Next-state for the arbitration state.
    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            // Point at the port that lost; while locked this is the
            // non-owner, which is where it must point after the unlock.
            prio_d = ~sel;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (accept) begin
            // An accepted request always comes from the owner while locked,
            // so its lock bit decides whether the lock continues.
            locked_d = req_lock_i[sel];
            owner_d  = sel;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 2'b00;
            resp_rdata_q <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q     <= 1'b0;
            owner_q      <= 1'b0;
`endif
        end else begin
            prio_q <= prio_d;
            for (int p = 0; p < 2; p++) begin
                resp_valid_q[p] <= grant[p];
                resp_err_q[p]   <= grant[p] & ~legal;
                resp_rdata_q[p] <= grant[p] ? resp_data : '0;
            end
`ifdef DMEM_ARB_LOCK_EN
            locked_q <= locked_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with a 128-byte behavioural data memory attached.
// The reference model keeps memory as a flat byte array and derives load
// results byte by byte. Arbitration is modelled as a priority bit.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int XLEN = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]           req_valid = '0;
    logic [1:0]           req_ready;
    logic [1:0]           req_we = '0;
    logic [1:0][XLEN-1:0] req_addr = '0;
    logic [1:0][XLEN-1:0] req_wdata = '0;
    logic [1:0][1:0]      req_size = '0;
    logic [1:0]           req_unsigned = '0;
    logic [1:0]           req_lock = '0;
    logic [1:0]           resp_valid;
    logic [1:0][XLEN-1:0] resp_rdata;
    logic [1:0]           resp_err;
    logic                 mem_valid;
    logic                 mem_we;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic [3:0]           mem_byte_enable;
    logic [XLEN-1:0]      mem_rdata;

    dmem_arbiter #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_we_i          (req_we),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_size_i        (req_size),
        .req_unsigned_i    (req_unsigned),
        .req_lock_i        (req_lock),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_err_o        (resp_err),
        .mem_valid_o       (mem_valid),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_byte_enable_o (mem_byte_enable),
        .mem_rdata_i       (mem_rdata)
    );

    // ---------------- attached memory (32 words) ----------------
    logic [31:0] env_mem [0:31];
    initial for (int i = 0; i < 32; i++) env_mem[i] = 32'h0;
    assign mem_rdata = env_mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_valid && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b]) env_mem[mem_addr[6:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:127];
    initial for (int i = 0; i < 128; i++) ref_mem[i] = 8'h0;
    logic       m_prio = 1'b0;
    logic [1:0] cur_grant = 2'b00;

    // Result record: {port, err, rdata}
    logic [33:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Performs one access on the byte-array memory and returns the response.
    function automatic logic [33:0] model_access(input logic port, input logic we,
                                                 input logic [31:0] addr, input logic [31:0] wdata,
                                                 input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        bit ok;
        ok = (size == 2'd0) || (size == 2'd1 && addr % 2 == 0) || (size == 2'd2 && addr % 4 == 0);
        if (!ok) return {port, 1'b1, 32'h0};
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            return {port, 1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return {port, 1'b0, v};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic v, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                            input logic lock);
        req_valid[p]    = v;
        req_we[p]       = we;
        req_addr[p]     = addr;
        req_wdata[p]    = wdata;
        req_size[p]     = size;
        req_unsigned[p] = uns;
        req_lock[p]     = lock;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_lock = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_prio = 1'b0;
        cur_grant = 2'b00;
        exp_q.delete();
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_resp_err", 32'(resp_err), 32'h0);
        check("reset_resp_rdata0", resp_rdata[0], 32'h0);
        check("reset_resp_rdata1", resp_rdata[1], 32'h0);
    endtask

    // Called at the negedge: grant and memory strobe against the model.
    task automatic pre_checks();
        logic [1:0] eg;
        logic [33:0] r;
        int p;
        eg = (req_valid == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : req_valid;
        check("ready", 32'(req_ready), 32'(eg));
        cur_grant = eg;
        if (eg != 2'b00) begin
            p = eg[1] ? 1 : 0;
            r = model_access(p[0], req_we[p], req_addr[p], req_wdata[p], req_size[p], req_unsigned[p]);
            check("mem_valid", 32'(mem_valid), 32'(!r[32]));
            exp_q.push_back(r);
        end else begin
            check("idle_mem_valid", 32'(mem_valid), 32'h0);
            check("idle_mem_we", 32'(mem_we), 32'h0);
            check("idle_mem_be", 32'(mem_byte_enable), 32'h0);
        end
    endtask

    // Called #1 after the posedge: response against the scoreboard.
    task automatic post_checks();
        logic [33:0] r;
        int p;
        check("resp_valid", 32'(resp_valid), 32'(cur_grant));
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            p = r[33] ? 1 : 0;
            check("resp_rdata", resp_rdata[p], r[31:0]);
            check("resp_err", 32'(resp_err[p]), 32'(r[32]));
        end
        if (cur_grant != 2'b00) m_prio = ~cur_grant[1];
    endtask

    task automatic run_cycle();
        @(negedge clk);
        pre_checks();
        @(posedge clk);
        #1;
        post_checks();
    endtask

    // Lock sequence step: explicit expected grant, response one cycle later.
    task automatic lock_cycle(input logic v0, input logic lock0, input logic v1, input logic [1:0] exp_g);
        set_port(0, v0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, lock0);
        set_port(1, v1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_ready", 32'(req_ready), 32'(exp_g));
        @(posedge clk);
        #1;
        check("lock_resp_valid", 32'(resp_valid), 32'(exp_g));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        exp_mv;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int p;
        logic [1:0] rr_exp [4];
        logic [1:0] sz;
        logic [31:0] a;

        vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 1'b1, 4'b1000, 32'h0, 32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h22, 32'h0,        2'd1, 1'b1, 1'b1, 4'b1100, 32'h0, 32'h0000ABCD, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h22, 32'h0,        2'd1, 1'b0, 1'b1, 4'b1100, 32'h0, 32'hFFFFABCD, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h05, 32'h0,        2'd1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h05, 32'h0000FFFF, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h04, 32'h0,        2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h31, 32'h0000005A, 2'd0, 1'b0, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h31, 32'h0,        2'd0, 1'b1, 1'b1, 4'b0010, 32'h0, 32'h0000005A, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'd3, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h12, 32'h0,        2'd2, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'd0, 1'b0, 1'b1, 4'b0001, 32'h0, 32'hFFFFFFEF, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h30, 32'h0,        2'd1, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h00005A00, 1'b0};

        apply_reset();

        // ---- table-driven single-port accesses ----
        foreach (vecs[i]) begin
            p = vecs[i].port ? 1 : 0;
            req_valid = 2'b00;
            set_port(p, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, 1'b0);
            @(negedge clk);
            check("tbl_mem_valid", 32'(mem_valid), 32'(vecs[i].exp_mv));
            check("tbl_mem_we", 32'(mem_we), 32'(vecs[i].exp_mv & vecs[i].we));
            check("tbl_mem_be", 32'(mem_byte_enable), 32'(vecs[i].exp_be));
            if (vecs[i].exp_mv) check("tbl_mem_addr", mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
            if (vecs[i].exp_mv && vecs[i].we) check("tbl_mem_wdata", mem_wdata, vecs[i].exp_wdata);
            pre_checks();
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            check("tbl_resp_rdata", resp_rdata[p], vecs[i].exp_rdata);
            check("tbl_resp_err", 32'(resp_err[p]), 32'(vecs[i].exp_err));
            post_checks();
        end

        // ---- round robin with both ports valid after reset ----
        apply_reset();
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'd1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(rr_exp[c]));
            pre_checks();
            @(posedge clk);
            #1;
            post_checks();
        end
        req_valid = 2'b00;
        run_cycle();

        // ---- randomized traffic from both ports ----
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < 2; q++) begin
                sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
                a = 32'($urandom_range(0, 127));
                if ($urandom_range(0, 9) < 8 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
                set_port(q, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a,
                         $urandom, sz, 1'($urandom_range(0, 1)), 1'b0);
            end
            run_cycle();
        end
        req_valid = 2'b00;
        run_cycle();

        // ---- lock behaviour (port 1 stalls only in the lock build) ----
        apply_reset();
        lock_cycle(1'b1, 1'b1, 1'b1, 2'b01);
`ifdef DMEM_ARB_LOCK_EN
        lock_cycle(1'b0, 1'b0, 1'b1, 2'b00);
        lock_cycle(1'b0, 1'b0, 1'b1, 2'b00);
`else
        lock_cycle(1'b0, 1'b0, 1'b1, 2'b10);
        lock_cycle(1'b0, 1'b0, 1'b1, 2'b10);
`endif
        lock_cycle(1'b1, 1'b0, 1'b1, 2'b01);
        lock_cycle(1'b0, 1'b0, 1'b1, 2'b10);
        req_valid = 2'b00;

        // ---- reset asserted during an accepted store ----
        apply_reset();
        set_port(0, 1'b1, 1'b1, 32'h40, 32'h11223344, 2'd2, 1'b0, 1'b0);
        run_cycle();
        set_port(0, 1'b1, 1'b1, 32'h40, 32'h99999999, 2'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        m_prio = 1'b0;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        pre_checks();
        @(posedge clk);
        #1;
        check("rst_word_kept", resp_rdata[1], 32'h11223344);
        post_checks();
        req_valid = 2'b00;

        // ---- final report ----
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
